// File: rtl/shift_sub_divider_if.sv
// Purpose: request/result bundle for the shift-and-subtract divider, plus next-state observation taps.
// Latency: none, wires only.
// Backpressure: none; the requester freezes the divider through stall, and the divider has no ready.
interface shift_sub_divider_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             stall;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             out_valid;
    logic             busy;
    logic [WIDTH-1:0] q_reg_next;
    logic [WIDTH:0]   rem_reg_next;
    logic [WIDTH-1:0] dvsr_reg_next;
    logic             finish_next;

    // Requester side: issues operands and stall, and observes results.
    modport master (
        output in_valid, stall, dividend, divisor,
        input  quotient, remainder, out_valid, busy,
        input  q_reg_next, rem_reg_next, dvsr_reg_next, finish_next
    );

    // Divider side.
    modport slave (
        input  in_valid, stall, dividend, divisor,
        output quotient, remainder, out_valid, busy,
        output q_reg_next, rem_reg_next, dvsr_reg_next, finish_next
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Purpose: iterative restoring unsigned divider, with an early exit for a zero divisor or a dividend smaller than the divisor.
// Latency: the result appears 1 cycle after accept on the early exit and WIDTH cycles otherwise; each stall cycle adds one.
// Backpressure: stall freezes all state; in_valid is only sampled in IDLE and there is no ready output.
module shift_sub_divider #(
    parameter int WIDTH     = 4,
    parameter int WIDTH_LOG = 2
) (
    input logic                 clk,
    input logic                 rst,
    shift_sub_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH_LOG:0] LAST_ITER = (WIDTH_LOG + 1)'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_reg, q_nxt;
    logic [WIDTH:0]     rem_reg, rem_nxt;
    logic [WIDTH-1:0]   dvsr_reg, dvsr_nxt;
    logic [WIDTH_LOG:0] cnt, cnt_nxt;
    logic               out_valid_reg, fin_nxt;

    // Trial value: the partial remainder shifted left, with the next dividend bit brought in.
    // rem_reg stays below the divisor, so its top bit is always zero. Keeping that bit in the
    // compare costs nothing and keeps the comparison honest if that invariant is ever broken.
    logic [WIDTH+1:0]   trial;
    logic               take;

    assign trial = {rem_reg, q_reg[WIDTH-1]};
    assign take  = (trial >= {2'b00, dvsr_reg});

    // Next-state and datapath decode. This is the unstalled next value, which the taps expose.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_reg;
        rem_nxt   = rem_reg;
        dvsr_nxt  = dvsr_reg;
        cnt_nxt   = cnt;
        fin_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    q_nxt     = bus.dividend;
                    dvsr_nxt  = bus.divisor;
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0 && dvsr_reg == '0) begin
                    // Division by zero: quotient saturates and the dividend is passed through as the remainder.
                    q_nxt     = '1;
                    rem_nxt   = {1'b0, q_reg};
                    state_nxt = DONE;
                    fin_nxt   = 1'b1;
                end else if (cnt == '0 && q_reg < dvsr_reg) begin
                    // Dividend smaller than divisor: the answer is known without iterating.
                    q_nxt     = '0;
                    rem_nxt   = {1'b0, q_reg};
                    state_nxt = DONE;
                    fin_nxt   = 1'b1;
                end else begin
                    if (take) begin
                        rem_nxt = (WIDTH + 1)'(trial - {2'b00, dvsr_reg});
                        q_nxt   = {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_nxt = trial[WIDTH:0];
                        q_nxt   = {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state_nxt = DONE;
                        fin_nxt   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register. Reset wins over stall, and stall holds everything, including the result strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q_reg         <= '0;
            rem_reg       <= '0;
            dvsr_reg      <= '0;
            cnt           <= '0;
            out_valid_reg <= 1'b0;
        end else if (!bus.stall) begin
            state         <= state_nxt;
            q_reg         <= q_nxt;
            rem_reg       <= rem_nxt;
            dvsr_reg      <= dvsr_nxt;
            cnt           <= cnt_nxt;
            out_valid_reg <= fin_nxt;
        end
    end

    assign bus.quotient      = q_reg;
    assign bus.remainder     = rem_reg[WIDTH-1:0];
    assign bus.out_valid     = out_valid_reg;
    assign bus.busy          = (state != IDLE);
    assign bus.q_reg_next    = q_nxt;
    assign bus.rem_reg_next  = rem_nxt;
    assign bus.dvsr_reg_next = dvsr_nxt;
    assign bus.finish_next   = fin_nxt;

endmodule
